// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth serial multiplier: FSM states,
// Booth digit map and derived widths.
package booth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    DIG_ZERO = 3'd0,
    DIG_POS1 = 3'd1,
    DIG_POS2 = 3'd2,
    DIG_NEG1 = 3'd3,
    DIG_NEG2 = 3'd4
  } digit_t;

  // Radix-4 recoding of the overlapping triplet {b[i+1], b[i], b[i-1]}
  function automatic digit_t booth_digit(input logic [2:0] bits);
    digit_t d;
    case (bits)
      3'b001, 3'b010: d = DIG_POS1;
      3'b011:         d = DIG_POS2;
      3'b100:         d = DIG_NEG2;
      3'b101, 3'b110: d = DIG_NEG1;
      default:        d = DIG_ZERO;
    endcase
    return d;
  endfunction

  // Two extra bits let unsigned operands ride through the signed datapath
  function automatic int unsigned ext_width(input int unsigned w);
    return w + 2;
  endfunction

  function automatic int unsigned iter_count(input int unsigned w);
    return (w + 2) / 2;
  endfunction

endpackage

// File: rtl/booth_r4_ppgen.sv
// Booth partial-product generator: selects 0, +-A or +-2A (EW+2 bits) for one digit.
module booth_r4_ppgen
  import booth_pkg::*;
#(
  parameter int unsigned EW = 36
) (
  input  logic [2:0]    bits,
  input  logic [EW-1:0] a,
  output logic [EW+1:0] pp_c,
  output logic          cin_c
);

  logic [EW+1:0] a_x1;
  logic [EW+1:0] a_x2;

  assign a_x1 = {{2{a[EW-1]}}, a};
  assign a_x2 = {a[EW-1], a, 1'b0};

  // Negative digits are formed as one's complement plus carry-in
  always_comb begin
    pp_c  = '0;
    cin_c = 1'b0;
    case (booth_digit(bits))
      DIG_POS1: pp_c = a_x1;
      DIG_POS2: pp_c = a_x2;
      DIG_NEG1: begin
        pp_c  = ~a_x1;
        cin_c = 1'b1;
      end
      DIG_NEG2: begin
        pp_c  = ~a_x2;
        cin_c = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/booth_r4_seq_mult_p.sv
// Serial radix-4 Booth multiplier, one digit per clock through a single shared adder,
// with signed/unsigned mode and a start/busy/done handshake.
module booth_r4_seq_mult_p
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 34
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned EW = ext_width(WIDTH);
  localparam int unsigned N  = iter_count(WIDTH);
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned PW = 2 * EW + 2;

  generate
    if (((WIDTH % 2) != 0) || (WIDTH < 4)) begin : g_bad_width
      $error("booth_r4_seq_mult_p: WIDTH must be even and >= 4");
    end
  endgenerate

  state_t        state;
  logic [CW-1:0] count;
  logic [EW-1:0] a_reg;
  logic [PW-1:0] p_reg;

  logic [EW-1:0] a_ext;
  logic [EW-1:0] b_ext;
  logic [EW:0]   hi;
  logic [EW+1:0] pp;
  logic          cin;
  logic [EW+1:0] sum;
  logic [PW-1:0] p_next;

  assign a_ext = signed_mode ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
  assign b_ext = signed_mode ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};

  booth_r4_ppgen #(
    .EW(EW)
  ) u_ppgen (
    .bits  (p_reg[2:0]),
    .a     (a_reg),
    .pp_c  (pp),
    .cin_c (cin)
  );

  // Shared adder on the upper accumulator, then arithmetic shift by one digit
  assign hi     = p_reg[PW-1:EW+1];
  assign sum    = {hi[EW], hi} + pp + {{(EW + 1){1'b0}}, cin};
  assign p_next = {sum[EW+1], sum, p_reg[EW:2]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      count   <= '0;
      a_reg   <= '0;
      p_reg   <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_reg <= a_ext;
            p_reg <= {(EW + 1)'(0), b_ext, 1'b0};
            count <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          p_reg <= p_next;
          count <= count + CW'(1);
          if (count == CW'(N - 1)) begin
            product <= p_next[2*WIDTH:1];
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
